shift_reg_seq_ctrl: RTL and testbench

Command sequencer for the universal shift register (WIDTH-bit, modes via s1/s0: 00 hold, 01 shift right with msb_in, 10 shift left with lsb_in, 11 parallel load).
- Accepts one command per valid/ready handshake (load, logical/arithmetic shift, rotate by N).
- Drives the register's mode, serial-in and parallel-in pins for the required number of cycles, then pulses done.
- Sits between a command source and one shift register instance, on the same clock.

---
 rtl/shift_reg_seq_ctrl_pkg.sv | 31 +++
 rtl/shift_reg_seq_ctrl_op_dec.sv | 48 ++++
 rtl/shift_reg_seq_ctrl.sv | 125 ++++++++++++
 tb/tb_shift_reg_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_seq_ctrl_pkg.sv
// Shared encodings for the shift-register command sequencer: op codes,
// controller states and the s1/s0 mode values of the universal shift register.
package shift_ctrl_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    function automatic logic op_is_shift(input logic [2:0] op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) ||
               (op == OP_ROR) || (op == OP_ASR);
    endfunction

endpackage

// File: rtl/shift_reg_seq_ctrl_op_dec.sv
// Maps a shift/rotate op plus the register's end bits onto the register's
// mode pins and serial inputs for one shift cycle.
module shift_op_dec
    import shift_ctrl_pkg::*;
(
    input  logic [2:0] i_op,
    input  logic       i_q_msb,
    input  logic       i_q_lsb,
    output logic       o_s1,
    output logic       o_s0,
    output logic       o_msb_in,
    output logic       o_lsb_in
);

    logic [1:0] w_mode;
    logic       w_msb_in;
    logic       w_lsb_in;

    always_comb begin
        w_mode   = MODE_HOLD;
        w_msb_in = 1'b0;
        w_lsb_in = 1'b0;
        case (i_op)
            OP_SHL: w_mode = MODE_SHL;
            OP_SHR: w_mode = MODE_SHR;
            OP_ROL: begin
                w_mode   = MODE_SHL;
                w_lsb_in = i_q_msb;
            end
            OP_ROR: begin
                w_mode   = MODE_SHR;
                w_msb_in = i_q_lsb;
            end
            // Sign bit is re-injected at the top on every step.
            OP_ASR: begin
                w_mode   = MODE_SHR;
                w_msb_in = i_q_msb;
            end
            default: w_mode = MODE_HOLD;
        endcase
    end

    assign o_s1     = w_mode[1];
    assign o_s0     = w_mode[0];
    assign o_msb_in = w_msb_in;
    assign o_lsb_in = w_lsb_in;

endmodule

// File: rtl/shift_reg_seq_ctrl.sv
// Command sequencer for a universal shift register: accepts one command per
// handshake, drives mode/serial/parallel pins for N cycles, then pulses done.
module shift_reg_seq_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_op_i,
    input  logic [CNT_W-1:0] cmd_amt_i,
    input  logic [WIDTH-1:0] cmd_data_i,
    input  logic [WIDTH-1:0] reg_q_i,
    output logic             s0_o,
    output logic             s1_o,
    output logic             msb_in_o,
    output logic             lsb_in_o,
    output logic [WIDTH-1:0] i_par_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [1:0]       dbg_state_o
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_data;

    logic w_accept;
    logic w_dec_s1;
    logic w_dec_s0;
    logic w_dec_msb_in;
    logic w_dec_lsb_in;
    logic w_unused_q;

    // Handshake: a command transfers on any posedge where cmd_valid_i and
    // cmd_ready_o are both high; ready is high only in IDLE and does not
    // depend on valid. Command inputs are don't-care at every other edge.
    assign w_accept = cmd_valid_i && (r_state == ST_IDLE);

    // Only the end bits of the register feed the serial inputs.
    assign w_unused_q = ^reg_q_i;

    shift_op_dec u_op_dec (
        .i_op     (r_op),
        .i_q_msb  (reg_q_i[WIDTH-1]),
        .i_q_lsb  (reg_q_i[0]),
        .o_s1     (w_dec_s1),
        .o_s0     (w_dec_s0),
        .o_msb_in (w_dec_msb_in),
        .o_lsb_in (w_dec_lsb_in)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= OP_NOP;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op   <= cmd_op_i;
                r_data <= cmd_data_i;
                r_cnt  <= cmd_amt_i;
            end else if (r_state == ST_SHIFT) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cmd_ready_o = 1'b0;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        s1_o        = 1'b0;
        s0_o        = 1'b0;
        msb_in_o    = 1'b0;
        lsb_in_o    = 1'b0;
        i_par_o     = '0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (w_accept) begin
                    if (cmd_op_i == OP_LOAD) begin
                        w_state_nxt = ST_LOAD;
                    end else if (op_is_shift(cmd_op_i) && (cmd_amt_i != '0)) begin
                        w_state_nxt = ST_SHIFT;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_LOAD: begin
                s1_o        = MODE_LOAD[1];
                s0_o        = MODE_LOAD[0];
                i_par_o     = r_data;
                w_state_nxt = ST_DONE;
            end
            ST_SHIFT: begin
                s1_o     = w_dec_s1;
                s0_o     = w_dec_s0;
                msb_in_o = w_dec_msb_in;
                lsb_in_o = w_dec_lsb_in;
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_shift_reg_seq_ctrl.sv
// Directed bench: the sequencer drives a behavioural universal shift register;
// every step is checked against hand-computed values.
module tb_shift_reg_seq_ctrl;
    import shift_ctrl_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst;
    logic             reg_rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [CNT_W-1:0] cmd_amt;
    logic [WIDTH-1:0] cmd_data;
    logic [WIDTH-1:0] reg_q;
    logic             s0;
    logic             s1;
    logic             msb_in;
    logic             lsb_in;
    logic [WIDTH-1:0] i_par;
    logic             busy;
    logic             done;
    logic [1:0]       dbg_state;

    int n_chk = 0;
    int n_err = 0;

    shift_reg_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_amt_i   (cmd_amt),
        .cmd_data_i  (cmd_data),
        .reg_q_i     (reg_q),
        .s0_o        (s0),
        .s1_o        (s1),
        .msb_in_o    (msb_in),
        .lsb_in_o    (lsb_in),
        .i_par_o     (i_par),
        .busy_o      (busy),
        .done_o      (done),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Universal shift register being sequenced, with its own reset.
    always @(posedge clk) begin
        if (reg_rst) begin
            reg_q <= '0;
        end else begin
            case ({s1, s0})
                2'b01:   reg_q <= {msb_in, reg_q[WIDTH-1:1]};
                2'b10:   reg_q <= {reg_q[WIDTH-2:0], lsb_in};
                2'b11:   reg_q <= i_par;
                default: reg_q <= reg_q;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [CNT_W-1:0] amt,
                        input logic [WIDTH-1:0] data);
        chk("acc_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_amt   = amt;
        cmd_data  = data;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] data);
        send(OP_LOAD, '0, data);
        step();
        chk("load_q", 32'(reg_q), 32'(data));
        step();
    endtask

    logic [WIDTH-1:0] rol_exp [5];
    logic             rol_lsb [5];
    logic [WIDTH-1:0] shl_exp [3];
    logic [2:0]       nop_ops [3];

    initial begin
        rol_exp = '{4'b0111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
        rol_lsb = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        shl_exp = '{4'b1110, 4'b1100, 4'b1000};
        nop_ops = '{OP_NOP, OP_RSVD, OP_SHR};

        rst       = 1'b1;
        reg_rst   = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_amt   = '0;
        cmd_data  = '0;
        repeat (2) step();
        rst     = 1'b0;
        reg_rst = 1'b0;

        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mode", 32'({s1, s0}), 32'd0);
        chk("rst_ser", 32'({msb_in, lsb_in}), 32'd0);
        chk("rst_ipar", 32'(i_par), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));

        // LOAD 1011
        send(OP_LOAD, '0, 4'b1011);
        chk("ld_mode", 32'({s1, s0}), 32'b11);
        chk("ld_ipar", 32'(i_par), 32'b1011);
        chk("ld_busy", 32'(busy), 32'd1);
        chk("ld_ready", 32'(cmd_ready), 32'd0);
        chk("ld_done0", 32'(done), 32'd0);
        step();
        chk("ld_done", 32'(done), 32'd1);
        chk("ld_q", 32'(reg_q), 32'b1011);
        chk("ld_hold", 32'({s1, s0}), 32'd0);
        chk("ld_ipar0", 32'(i_par), 32'd0);
        chk("ld_dbusy", 32'(busy), 32'd1);
        step();
        chk("ld_idle_ready", 32'(cmd_ready), 32'd1);
        chk("ld_idle_done", 32'(done), 32'd0);

        // ROR 1 from 1011
        send(OP_ROR, 3'd1, '0);
        chk("ror_mode", 32'({s1, s0}), 32'b01);
        chk("ror_msb", 32'(msb_in), 32'd1);
        chk("ror_lsb", 32'(lsb_in), 32'd0);
        step();
        chk("ror_done", 32'(done), 32'd1);
        chk("ror_q", 32'(reg_q), 32'b1101);
        step();

        // ROL 5 from 1011
        do_load(4'b1011);
        send(OP_ROL, 3'd5, '0);
        for (int i = 0; i < 5; i++) begin
            chk("rol_mode", 32'({s1, s0}), 32'b10);
            chk("rol_lsb", 32'(lsb_in), 32'(rol_lsb[i]));
            chk("rol_done0", 32'(done), 32'd0);
            step();
            chk("rol_q", 32'(reg_q), 32'(rol_exp[i]));
        end
        chk("rol_done", 32'(done), 32'd1);
        step();

        // ASR 2 from 1000
        do_load(4'b1000);
        send(OP_ASR, 3'd2, '0);
        chk("asr_msb1", 32'(msb_in), 32'd1);
        step();
        chk("asr_q1", 32'(reg_q), 32'b1100);
        chk("asr_done0", 32'(done), 32'd0);
        chk("asr_msb2", 32'(msb_in), 32'd1);
        step();
        chk("asr_q2", 32'(reg_q), 32'b1110);
        chk("asr_done", 32'(done), 32'd1);
        step();

        // SHL 3 from 0111
        do_load(4'b0111);
        send(OP_SHL, 3'd3, '0);
        for (int i = 0; i < 3; i++) begin
            chk("shl_mode", 32'({s1, s0}), 32'b10);
            chk("shl_lsb", 32'(lsb_in), 32'd0);
            step();
            chk("shl_q", 32'(reg_q), 32'(shl_exp[i]));
        end
        chk("shl_done", 32'(done), 32'd1);
        step();

        // SHR 7 (amount beyond width) from 1011 clears the register
        do_load(4'b1011);
        send(OP_SHR, 3'd7, '0);
        for (int i = 0; i < 7; i++) begin
            chk("shr7_done0", 32'(done), 32'd0);
            chk("shr7_msb", 32'(msb_in), 32'd0);
            step();
        end
        chk("shr7_done", 32'(done), 32'd1);
        chk("shr7_q", 32'(reg_q), 32'd0);
        step();

        // NOP, reserved op and zero-amount shift complete immediately
        do_load(4'b1001);
        for (int i = 0; i < 3; i++) begin
            send(nop_ops[i], '0, 4'b0110);
            chk("nop_mode", 32'({s1, s0}), 32'd0);
            chk("nop_done", 32'(done), 32'd1);
            chk("nop_busy", 32'(busy), 32'd1);
            chk("nop_ready", 32'(cmd_ready), 32'd0);
            step();
            chk("nop_q", 32'(reg_q), 32'b1001);
            chk("nop_ready1", 32'(cmd_ready), 32'd1);
            chk("nop_done1", 32'(done), 32'd0);
        end

        // Reset during the 2nd SHIFT cycle of ROR 4 from 1011
        do_load(4'b1011);
        send(OP_ROR, 3'd4, '0);
        step();
        chk("rr_q1", 32'(reg_q), 32'b1101);
        chk("rr_mode", 32'({s1, s0}), 32'b01);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rr_hold", 32'({s1, s0}), 32'd0);
        chk("rr_busy", 32'(busy), 32'd0);
        chk("rr_ready", 32'(cmd_ready), 32'd1);
        chk("rr_done", 32'(done), 32'd0);
        chk("rr_q2", 32'(reg_q), 32'b1110);
        send(OP_LOAD, '0, 4'b0101);
        chk("rr_ld_mode", 32'({s1, s0}), 32'b11);
        chk("rr_ld_ipar", 32'(i_par), 32'b0101);
        step();
        chk("rr_ld_done", 32'(done), 32'd1);
        chk("rr_ld_q", 32'(reg_q), 32'b0101);
        step();
        chk("rr_end_ready", 32'(cmd_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
